// File: rtl/sar_pkg.sv
// -----------------------------------------------------------------------------
// sar_pkg
// Shared constants and helpers for the SAR averaging capture block.
//   SAR_CODE_W     : width of one SAR conversion code
//   SAR_FIFO_DEPTH : depth of the optional result FIFO
//   SAR_FIFO_AW    : pointer width of the optional result FIFO
//   sar_sum_w()    : sum width needed for 2^avg_log2 codes without overflow
// -----------------------------------------------------------------------------
package sar_pkg;

  localparam int SAR_CODE_W     = 4;
  localparam int SAR_FIFO_DEPTH = 4;
  localparam int SAR_FIFO_AW    = 2;

  // 15 * 2^avg_log2 always fits in SAR_CODE_W + avg_log2 bits.
  function automatic int sar_sum_w(input int avg_log2);
    return SAR_CODE_W + avg_log2;
  endfunction

endpackage

// File: rtl/sar_result_fifo.sv
// -----------------------------------------------------------------------------
// sar_result_fifo
// Small show-ahead FIFO holding finished averaging results. The head entry is
// always visible on o_head; o_empty / o_full report occupancy.
// A push while full is accepted only when a pop happens in the same cycle;
// otherwise it is ignored (the caller flags the loss). A pop while empty is
// ignored.
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   i_push  in   write i_data
//   i_data  in   WIDTH  entry to write
//   i_pop   in   remove head entry
//   o_head  out  WIDTH  head entry (valid when !o_empty)
//   o_full  out  all DEPTH entries occupied
//   o_empty out  no entries occupied
// -----------------------------------------------------------------------------
module sar_result_fifo #(
  parameter  int WIDTH = 6,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign w_pop_ok  = i_pop & ~o_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_head    = r_mem[r_rd_ptr];

  // Explicit wrap so non power-of-two depths also work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop_ok)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is reset so the head reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_wr_ptr == AW'(i)) r_mem[i] <= i_data;
      end
    end
  end

endmodule

// File: rtl/sar_avg_capture.sv
// -----------------------------------------------------------------------------
// sar_avg_capture
// Captures SAR codes on conv_done, sums 2^AVG_LOG2 consecutive codes and
// presents the sum and truncated average on a valid/ready port. Results lost
// to back-pressure set the sticky overrun flag.
//
// Build option: define SAR_AVG_FIFO_EN to replace the single output holding
// register with a 4-entry show-ahead result FIFO.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   bitin      in   4       SAR code, valid when conv_done=1
//   conv_done  in   sample strobe, one sample per high cycle
//   enable     in   1 = accumulate, 0 = discard samples and clear partial sum
//   out_data   out  4       averaged code (out_sum >> AVG_LOG2)
//   out_sum    out  SUM_W   sum of the last 2^AVG_LOG2 codes
//   out_valid  out  result available
//   out_ready  in   consumer accepts result
//   overrun    out  sticky: a result was dropped
//   ovr_clr    in   synchronous clear of overrun (a new drop wins)
// -----------------------------------------------------------------------------
module sar_avg_capture
  import sar_pkg::*;
#(
  parameter  int AVG_LOG2 = 2,
  localparam int SUM_W    = sar_sum_w(AVG_LOG2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SAR_CODE_W-1:0] bitin,
  input  logic                  conv_done,
  input  logic                  enable,
  output logic [SAR_CODE_W-1:0] out_data,
  output logic [SUM_W-1:0]      out_sum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  input  logic                  ovr_clr
);

  // With AVG_LOG2 = 0 the counter keeps one bit that simply stays at 0,
  // so every sample is the last of its group.
  localparam int              CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] N_M1 = CNT_W'((1 << AVG_LOG2) - 1);

  logic [SUM_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_overrun;

  logic             w_last;
  logic [SUM_W-1:0] w_result;
  logic             w_drop;

  assign w_last   = conv_done & enable & (r_cnt == N_M1);
  assign w_result = r_acc + SUM_W'(bitin);

  // ---------------------------------------------------------------------------
  // Accumulator
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (!enable) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (conv_done) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_result;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
`ifdef SAR_AVG_FIFO_EN
  logic             w_full;
  logic             w_empty;
  logic [SUM_W-1:0] w_head;

  sar_result_fifo #(
    .WIDTH (SUM_W),
    .DEPTH (SAR_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_last),
    .i_data  (w_result),
    .i_pop   (out_ready),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // When full the FIFO is never empty, so out_ready alone means a pop.
  assign w_drop    = w_last & w_full & ~out_ready;
  assign out_valid = ~w_empty;
  assign out_sum   = w_head;
`else
  logic             r_valid;
  logic [SUM_W-1:0] r_hold;

  // A held result leaving this cycle frees the register for a new one.
  assign w_drop = w_last & r_valid & ~out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_hold  <= '0;
    end else if (w_last && (!r_valid || out_ready)) begin
      r_valid <= 1'b1;
      r_hold  <= w_result;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_sum   = r_hold;
`endif

  assign out_data = out_sum[SUM_W-1:AVG_LOG2];

  // ---------------------------------------------------------------------------
  // Sticky overrun; a drop in the same cycle as ovr_clr keeps it set.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign overrun = r_overrun;

endmodule

// File: tb/tb_sar_avg_capture.sv
// -----------------------------------------------------------------------------
// tb_sar_avg_capture
// Two instances share all inputs: AVG_LOG2=2 (u_dut) and AVG_LOG2=0 (u_dut0).
// A queue-based model of each result path is compared against the outputs on
// every falling edge; directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_sar_avg_capture;

`ifdef SAR_AVG_FIFO_EN
  localparam int MDEPTH = 4;
`else
  localparam int MDEPTH = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] bitin;
  logic       conv_done;
  logic       enable;
  logic       out_ready;
  logic       ovr_clr;

  logic [3:0] a_data;
  logic [5:0] a_sum;
  logic       a_valid;
  logic       a_ovr;
  logic [3:0] z_data;
  logic [3:0] z_sum;
  logic       z_valid;
  logic       z_ovr;

  sar_avg_capture #(.AVG_LOG2(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .bitin(bitin), .conv_done(conv_done),
    .enable(enable), .out_data(a_data), .out_sum(a_sum), .out_valid(a_valid),
    .out_ready(out_ready), .overrun(a_ovr), .ovr_clr(ovr_clr)
  );

  sar_avg_capture #(.AVG_LOG2(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bitin(bitin), .conv_done(conv_done),
    .enable(enable), .out_data(z_data), .out_sum(z_sum), .out_valid(z_valid),
    .out_ready(out_ready), .overrun(z_ovr), .ovr_clr(ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: index 0 -> AVG_LOG2=2, index 1 -> AVG_LOG2=0
  int gsum [2];
  int gcnt [2];
  bit movr [2];
  int qa[$];
  int qz[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      gsum[k] = 0;
      gcnt[k] = 0;
      movr[k] = 1'b0;
    end
    qa.delete();
    qz.delete();
  endtask

  // One clock edge worth of behaviour, from the pre-edge input values.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int  n;
      bit  push;
      int  val;
      int  sz;
      bit  drop;
      n    = (k == 0) ? 4 : 1;
      push = 1'b0;
      val  = 0;
      drop = 1'b0;
      if (!enable) begin
        gsum[k] = 0;
        gcnt[k] = 0;
      end else if (conv_done) begin
        gsum[k] += int'(bitin);
        gcnt[k]++;
        if (gcnt[k] == n) begin
          push    = 1'b1;
          val     = gsum[k];
          gsum[k] = 0;
          gcnt[k] = 0;
        end
      end
      if (k == 0) begin
        if (out_ready && qa.size() > 0) void'(qa.pop_front());
        sz = qa.size();
        if (push) begin
          if (sz < MDEPTH) qa.push_back(val);
          else drop = 1'b1;
        end
      end else begin
        if (out_ready && qz.size() > 0) void'(qz.pop_front());
        sz = qz.size();
        if (push) begin
          if (sz < MDEPTH) qz.push_back(val);
          else drop = 1'b1;
        end
      end
      if (drop) movr[k] = 1'b1;
      else if (ovr_clr) movr[k] = 1'b0;
    end
  endtask

  // Inputs change on the falling edge; the model advances at the rising edge.
  task automatic cyc(input bit c, input int v, input bit e, input bit r, input bit oc);
    conv_done = c;
    bitin     = v[3:0];
    enable    = e;
    out_ready = r;
    ovr_clr   = oc;
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic arst();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_valid", int'(a_valid), 0);
    chk("arst_sum", int'(a_sum), 0);
    chk("arst_data", int'(a_data), 0);
    chk("arst_ovr", int'(a_ovr), 0);
    chk("arst_valid0", int'(z_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Continuous comparison against the model.
  always @(negedge clk) begin
    chk("valid_a", int'(a_valid), int'(qa.size() > 0));
    chk("ovr_a", int'(a_ovr), int'(movr[0]));
    if (qa.size() > 0) begin
      chk("sum_a", int'(a_sum), qa[0]);
      chk("data_a", int'(a_data), qa[0] >> 2);
    end
    chk("valid_z", int'(z_valid), int'(qz.size() > 0));
    chk("ovr_z", int'(z_ovr), int'(movr[1]));
    if (qz.size() > 0) begin
      chk("sum_z", int'(z_sum), qz[0]);
      chk("data_z", int'(z_data), qz[0]);
    end
  end

  initial begin
    rst_n     = 1'b0;
    conv_done = 1'b0;
    bitin     = 4'd0;
    enable    = 1'b1;
    out_ready = 1'b0;
    ovr_clr   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(a_valid), 0);
    chk("rst_sum", int'(a_sum), 0);
    chk("rst_ovr", int'(a_ovr), 0);
    rst_n = 1'b1;

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 55), int'($urandom_range(0, 15)),
          ($urandom_range(0, 99) < 95), ($urandom_range(0, 99) < 50),
          ($urandom_range(0, 99) < 4));
      if ($urandom_range(0, 999) < 3) arst();
    end

    // Codes 3,5,7,9 with ready high
    arst();
    cyc(1, 3, 1, 1, 0);
    cyc(1, 5, 1, 1, 0);
    cyc(1, 7, 1, 1, 0);
    cyc(1, 9, 1, 1, 0);
    chk("basic_valid", int'(a_valid), 1);
    chk("basic_sum", int'(a_sum), 24);
    chk("basic_data", int'(a_data), 6);
    cyc(0, 0, 1, 1, 0);
    chk("basic_drop", int'(a_valid), 0);

    // Back-pressure and overrun
    arst();
`ifdef SAR_AVG_FIFO_EN
    for (int i = 0; i < 20; i++) cyc(1, i / 4 + 1, 1, 0, 0);
    chk("fifo_ovr", int'(a_ovr), 1);
    chk("fifo_head", int'(a_sum), 4);
    cyc(0, 0, 1, 0, 1);
    chk("fifo_clr", int'(a_ovr), 0);
    for (int i = 0; i < 3; i++) cyc(1, 6, 1, 0, 0);
    cyc(1, 6, 1, 1, 0);
    chk("fifo_pushpop_ovr", int'(a_ovr), 0);
    chk("fifo_pushpop_head", int'(a_sum), 8);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0);
    chk("fifo_drained", int'(a_valid), 0);
`else
    for (int i = 0; i < 8; i++) cyc(1, i / 4 + 1, 1, 0, 0);
    chk("hold_sum", int'(a_sum), 4);
    chk("hold_ovr", int'(a_ovr), 1);
    chk("hold_data", int'(a_data), 1);
    cyc(0, 0, 1, 1, 1);
    chk("hold_clr", int'(a_ovr), 0);
    chk("hold_taken", int'(a_valid), 0);
`endif

    // Enable abort discards the partial sum
    arst();
    cyc(1, 15, 1, 1, 0);
    cyc(1, 15, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 15, 1, 1, 0);
    cyc(1, 15, 1, 1, 0);
    chk("abort_nores", int'(a_valid), 0);
    cyc(1, 15, 1, 1, 0);
    cyc(1, 15, 1, 1, 0);
    chk("abort_valid", int'(a_valid), 1);
    chk("abort_sum", int'(a_sum), 60);
    chk("abort_data", int'(a_data), 15);

    // Asynchronous reset with a held result and a partial group
    arst();
    for (int i = 0; i < 6; i++) cyc(1, 2, 1, 0, 0);
    chk("pre_arst_valid", int'(a_valid), 1);
    arst();
    for (int i = 0; i < 4; i++) cyc(1, 2, 1, 0, 0);
    chk("post_arst_sum", int'(a_sum), 8);

    // AVG_LOG2 = 0 passes every code straight through
    arst();
    cyc(1, 9, 1, 1, 0);
    chk("avg0_first", int'(z_data), 9);
    cyc(1, 4, 1, 1, 0);
    chk("avg0_second", int'(z_data), 4);
    chk("avg0_sum", int'(z_sum), 4);
    cyc(0, 0, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
